// File: rtl/mips_wb_trace_buffer.sv
// Write-back trace buffer: captures every architectural register write from
// mips_processor as a timestamped record and streams the records out in order
// over a valid/ready interface. Overflow drops the newest record and counts it.
module mips_wb_trace_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CYC_W  = 16,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              instr_in,
    input  logic [31:0]              wdata_in,
    input  logic [4:0]               wreg_in,
    input  logic                     reg_write_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CYC_W-1:0]         out_cycle,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [4:0]               out_reg,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [CYC_W-1:0] cyc;
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [4:0]       rg;
        logic [31:0]      data;
    } rec_t;

    rec_t              mem_q [DEPTH];
    rec_t              mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic push, pop, full, do_push, do_drop;
    rec_t head;

    // Handshake qualifiers: a push is accepted into a full FIFO only if the head leaves the same cycle.
    always_comb begin
        push    = enable && reg_write_in && (wreg_in != 5'd0);
        pop     = (count_q != '0) && out_ready;
        full    = (count_q == CNT_W'(DEPTH));
        do_push = push && (!full || pop);
        do_drop = push && full && !pop;
    end

    // Next-state for storage, pointers, occupancy and overflow bookkeeping; clear wins over push/pop.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        cyc_d      = cyc_q + 1'b1;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q].cyc   = cyc_q;
                mem_d[wr_ptr_q].pc    = pc_in;
                mem_d[wr_ptr_q].instr = instr_in;
                mem_d[wr_ptr_q].rg    = wreg_in;
                mem_d[wr_ptr_q].data  = wdata_in;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(pop);
            if (do_drop) begin
                overflow_d = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cyc_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cyc_q      <= cyc_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Head record is driven only from flops; fields read as zero while the FIFO is empty.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        out_valid  = (count_q != '0);
        out_cycle  = out_valid ? head.cyc   : '0;
        out_pc     = out_valid ? head.pc    : '0;
        out_instr  = out_valid ? head.instr : '0;
        out_reg    = out_valid ? head.rg    : '0;
        out_data   = out_valid ? head.data  : '0;
        count      = count_q;
        overflow   = overflow_q;
        drop_count = drop_q;
    end

endmodule

// File: tb/tb_mips_wb_trace_buffer.sv
// Bench for mips_wb_trace_buffer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference of the trace FIFO.
// Two instances share stimulus: a default one and a narrow one (6-bit stamp,
// 2-bit drop counter) that exercises stamp wrap and drop saturation.
module tb_mips_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, clear, reg_write_in, out_ready;
    logic [31:0] pc_in, instr_in, wdata_in;
    logic [4:0]  wreg_in;

    logic        a_valid, b_valid;
    logic [15:0] a_cycle;
    logic [5:0]  b_cycle;
    logic [31:0] a_pc, a_instr, a_data, b_pc, b_instr, b_data;
    logic [4:0]  a_reg, b_reg;
    logic [3:0]  a_count, b_count;
    logic        a_ovf, b_ovf;
    logic [7:0]  a_drop;
    logic [1:0]  b_drop;

    always #5 clk = ~clk;

    mips_wb_trace_buffer #(.DEPTH(8), .CYC_W(16), .DROP_W(8)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .pc_in(pc_in), .instr_in(instr_in), .wdata_in(wdata_in),
        .wreg_in(wreg_in), .reg_write_in(reg_write_in),
        .out_valid(a_valid), .out_ready(out_ready), .out_cycle(a_cycle),
        .out_pc(a_pc), .out_instr(a_instr), .out_reg(a_reg), .out_data(a_data),
        .count(a_count), .overflow(a_ovf), .drop_count(a_drop)
    );

    mips_wb_trace_buffer #(.DEPTH(8), .CYC_W(6), .DROP_W(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .pc_in(pc_in), .instr_in(instr_in), .wdata_in(wdata_in),
        .wreg_in(wreg_in), .reg_write_in(reg_write_in),
        .out_valid(b_valid), .out_ready(out_ready), .out_cycle(b_cycle),
        .out_pc(b_pc), .out_instr(b_instr), .out_reg(b_reg), .out_data(b_data),
        .count(b_count), .overflow(b_ovf), .drop_count(b_drop)
    );

    // Reference model: unbounded cycle count, queue of records, plain drop tally.
    typedef struct {
        int unsigned cyc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rg;
        logic [31:0] data;
    } rec_t;

    localparam int unsigned DEPTH = 8;
    rec_t        mq[$];
    int unsigned m_cyc;
    int unsigned m_drops;
    bit          m_ovf;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cyc   = 0;
        m_drops = 0;
        m_ovf   = 0;
    endtask

    task automatic check_all();
        rec_t h;
        bit   v;
        v = (mq.size() != 0);
        if (v) h = mq[0];
        else   h = '{cyc: 0, pc: '0, instr: '0, rg: '0, data: '0};
        check("a_valid", a_valid, v);
        check("a_count", a_count, mq.size());
        check("a_cycle", a_cycle, h.cyc % 65536);
        check("a_pc",    a_pc,    h.pc);
        check("a_instr", a_instr, h.instr);
        check("a_reg",   a_reg,   h.rg);
        check("a_data",  a_data,  h.data);
        check("a_ovf",   a_ovf,   m_ovf);
        check("a_drop",  a_drop,  sat(m_drops, 255));
        check("b_valid", b_valid, v);
        check("b_count", b_count, mq.size());
        check("b_cycle", b_cycle, h.cyc % 64);
        check("b_data",  b_data,  h.data);
        check("b_ovf",   b_ovf,   m_ovf);
        check("b_drop",  b_drop,  sat(m_drops, 3));
    endtask

    // One clock: apply inputs at the negedge, advance the model, check at the next negedge.
    task automatic step(input bit en, input bit clr, input bit rw, input logic [4:0] rg,
                        input logic [31:0] data, input logic [31:0] pc, input bit rdy);
        bit   push, pop;
        rec_t r;
        enable       = en;
        clear        = clr;
        reg_write_in = rw;
        wreg_in      = rg;
        wdata_in     = data;
        pc_in        = pc;
        instr_in     = $urandom;
        out_ready    = rdy;

        push = en && rw && (rg != 0);
        pop  = (mq.size() != 0) && rdy;
        if (clr) begin
            mq.delete();
            m_drops = 0;
            m_ovf   = 0;
        end else if (push && mq.size() == DEPTH && !pop) begin
            m_drops++;
            m_ovf = 1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                r = '{cyc: m_cyc, pc: pc, instr: instr_in, rg: rg, data: data};
                mq.push_back(r);
            end
        end
        m_cyc++;

        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic wr(input logic [4:0] rg, input logic [31:0] data, input logic [31:0] pc, input bit rdy);
        step(1'b1, 1'b0, 1'b1, rg, data, pc, rdy);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; clear = 1'b0; reg_write_in = 1'b0; out_ready = 1'b0;
        pc_in = '0; instr_in = '0; wdata_in = '0; wreg_in = '0;
        model_reset();

        // Reset state
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Basic capture: writes at stamps 2 and 3
        idle(1'b0);
        idle(1'b0);
        wr(5'd8, 32'd5, 32'd0, 1'b0);
        wr(5'd9, 32'd10, 32'd4, 1'b0);
        check("basic_count", a_count, 4'd2);
        check("basic_cyc0", a_cycle, 16'd2);
        check("basic_reg0", a_reg, 5'd8);
        check("basic_data0", a_data, 32'd5);
        idle(1'b1);
        check("basic_cyc1", a_cycle, 16'd3);
        check("basic_pc1", a_pc, 32'd4);
        check("basic_reg1", a_reg, 5'd9);
        idle(1'b1);
        check("basic_empty", a_valid, 1'b0);

        // $zero filter and enable gating
        step(1'b1, 1'b0, 1'b1, 5'd0, 32'h11, 32'h40, 1'b0);
        step(1'b0, 1'b0, 1'b1, 5'd10, 32'h22, 32'h44, 1'b0);
        check("filter_count", a_count, 4'd0);
        check("filter_valid", a_valid, 1'b0);

        // Overflow: 11 writes into 8 entries, then drain
        for (int i = 0; i < 11; i++) wr(5'(i + 1), 32'(100 + i), 32'(4 * i), 1'b0);
        check("ovf_count", a_count, 4'd8);
        check("ovf_flag", a_ovf, 1'b1);
        check("ovf_drop", a_drop, 8'd3);
        check("ovf_head", a_data, 32'd100);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Full with simultaneous push and pop
        step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) wr(5'(i + 3), 32'(200 + i), 32'(8 * i), 1'b0);
        wr(5'd31, 32'hCAFE, 32'h100, 1'b1);
        check("fullpp_count", a_count, 4'd8);
        check("fullpp_ovf", a_ovf, 1'b0);
        check("fullpp_head", a_data, 32'd201);

        // Saturation: 6 drops, then clear
        for (int i = 0; i < 6; i++) wr(5'd7, 32'(300 + i), 32'd0, 1'b0);
        check("sat_a", a_drop, 8'd6);
        check("sat_b", b_drop, 2'd3);
        step(1'b1, 1'b1, 1'b1, 5'd4, 32'd1, 32'd0, 1'b1);
        check("clr_count", a_count, 4'd0);
        check("clr_ovf", a_ovf, 1'b0);
        check("clr_drop", b_drop, 2'd0);
        wr(5'd5, 32'd55, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Asynchronous reset with 4 records queued
        for (int i = 0; i < 4; i++) wr(5'(i + 12), 32'(400 + i), 32'd0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("areset_valid", a_valid, 1'b0);
        check("areset_count", a_count, 4'd0);
        check("areset_b_count", b_count, 4'd0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        idle(1'b0);
        wr(5'd6, 32'd66, 32'd8, 1'b0);
        check("areset_stamp", a_cycle, 16'd1);
        idle(1'b1);

        // Randomized traffic: congested phase, then mostly draining phase
        for (int i = 0; i < 600; i++) begin
            bit       en, clr, rw, rdy;
            logic [4:0] rg;
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 59) == 0);
            rw  = ($urandom_range(0, 3) != 0);
            rg  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(en, clr, rw, rg, $urandom, $urandom, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_wb_trace_buffer.md
Name: mips_wb_trace_buffer

Overview:
- Sits directly downstream of mips_processor.
- Consumes its per-cycle debug outputs (pc_out, instruction, alu_result, write_reg, reg_write) and captures every architectural register write as a timestamped trace record.
- Records are held in a FIFO and drained over a valid/ready stream, so a bench or debug UART can read the write history without sampling every cycle.
- Overflow is detected and counted, never silent.

Parameters:
- DEPTH, 8: number of FIFO entries; power of two, ≥2.
- CYC_W, 16: width of the free-running cycle timestamp.
- DROP_W, 8: width of the saturating dropped-record counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  capture enable; 0 = ignore writes (timestamp still runs)
- clear  in  1  synchronous flush of FIFO, drop counter and overflow flag
- pc_in  in  32  PC of the instruction in flight (from pc_out)
- instr_in  in  32  instruction word
- wdata_in  in  32  write-back value (from alu_result)
- wreg_in  in  5  destination register (from write_reg)
- reg_write_in  in  1  write-back strobe
- out_valid  out  1  a record is available at the head
- out_ready  in  1  consumer accepts head record
- out_cycle  out  CYC_W  timestamp of head record
- out_pc  out  32  PC of head record
- out_instr  out  32  instruction of head record
- out_reg  out  5  destination register of head record
- out_data  out  32  written value of head record
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one record dropped since reset/clear
- drop_count  out  DROP_W  records dropped, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, so out_valid=0 and count=0.
  - Read and write pointers = 0.
  - Cycle counter = 0; overflow=0; drop_count=0.
  - out_* data fields = 0.
- Cycle counter:
  - Increments by 1 every clk edge out of reset; wraps at 2^CYC_W−1 → 0.
  - The stamp stored is the counter value before that edge's increment.
  - Not affected by clear or enable.
- Capture condition (push): enable && reg_write_in && wreg_in!=0. Writes to $zero are never recorded.
- Pop: out_valid && out_ready.
- Latency:
  - A push into an empty FIFO makes out_valid=1 on the following edge.
  - Head fields are stable while out_valid=1 and out_ready=0.
  - No combinational path from inputs to out_*.
- Full, push, no pop: record dropped; FIFO unchanged; overflow←1; drop_count += 1, saturating at 2^DROP_W−1.
- Full, push, pop same cycle: head leaves, new record enters at tail; count stays DEPTH; no drop.
- Empty, pop attempted: impossible (out_valid=0); out_ready ignored.
- Push and pop, 0<count<DEPTH: count unchanged, order preserved.
- Pointers: wrap modulo DEPTH; full/empty distinguished via count (or an extra pointer bit).
- clear=1:
  - Next edge: count=0, out_valid=0, overflow=0, drop_count=0.
  - Any simultaneous push or pop is discarded (clear has priority).
- Reset asserted mid-stream: all state returns to reset values immediately, regardless of clk.
- Ordering: strict FIFO; records emerge in capture order with monotonically increasing stamps, modulo wrap.

Test Plan:
- Basic capture:
  - Stimulus: after reset, with out_ready=0, drive reg_write_in=1, wreg_in=8, wdata_in=5, pc_in=0 at cycle 2; then wreg_in=9, wdata_in=10, pc_in=4 at cycle 3.
  - Response: count=2; head={cycle 2, pc 0, reg 8, data 5}.
  - Then out_ready=1: next head={cycle 3, pc 4, reg 9, data 10}; out_valid=0 afterwards.
- $zero filter / enable:
  - Stimulus: reg_write_in=1 with wreg_in=0; then wreg_in=10 with enable=0.
  - Response: count stays 0; out_valid never asserts.
- Overflow (DEPTH=8, out_ready=0): 11 consecutive writes → count=8; overflow=1; drop_count=3; the 8 drained records are the first 8 in order.
- Full with simultaneous push+pop: FIFO full, out_ready=1 and push in the same cycle → count stays 8; overflow stays 0; tail holds the new record.
- Saturation (DROP_W=2): 6 drops → drop_count=3. Then clear=1 for one cycle → count=0, overflow=0, drop_count=0; the cycle counter keeps running.
- Async reset mid-operation: with 4 records queued, pull reset low between edges → out_valid=0 and count=0 without waiting for a clk edge. After release, first capture at edge k carries stamp k−1 relative to the reset release.
